// File: rtl/ex_operand_stage.sv
// Decode-to-ALU pipeline register: resolves operand forwarding, immediate/PC
// selection and load-use bubbles, and presents registered ALU operands.
module ex_operand_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic                  flush,
  input  logic                  in_valid,
  input  logic [3:0]            in_alu_control,
  input  logic [REG_ADDR_W-1:0] in_rs1_addr,
  input  logic [REG_ADDR_W-1:0] in_rs2_addr,
  input  logic [XLEN-1:0]       in_rs1_data,
  input  logic [XLEN-1:0]       in_rs2_data,
  input  logic [XLEN-1:0]       in_imm,
  input  logic [XLEN-1:0]       in_pc,
  input  logic                  in_use_imm,
  input  logic                  in_use_pc,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic                  in_reg_write,
  input  logic                  in_is_load,
  input  logic                  fwd1_valid,
  input  logic                  fwd1_reg_write,
  input  logic                  fwd1_is_load,
  input  logic [REG_ADDR_W-1:0] fwd1_rd_addr,
  input  logic [XLEN-1:0]       fwd1_result,
  input  logic                  fwd2_valid,
  input  logic                  fwd2_reg_write,
  input  logic [REG_ADDR_W-1:0] fwd2_rd_addr,
  input  logic [XLEN-1:0]       fwd2_result,
  output logic                  hazard_stall,
  output logic                  out_valid,
  output logic [3:0]            alu_control,
  output logic [XLEN-1:0]       source_A,
  output logic [XLEN-1:0]       source_B,
  output logic [XLEN-1:0]       out_store_data,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic                  out_reg_write,
  output logic                  out_is_load
);

  logic            fwd1_hit_rs1, fwd1_hit_rs2;
  logic            fwd2_hit_rs1, fwd2_hit_rs2;
  logic            fwd1_writes, fwd2_writes;
  logic            rs2_used;
  logic            capture;
  logic [XLEN-1:0] fwd_a, fwd_b;

  always_comb begin
    fwd1_writes  = fwd1_valid & fwd1_reg_write & (fwd1_rd_addr != '0);
    fwd2_writes  = fwd2_valid & fwd2_reg_write & (fwd2_rd_addr != '0);
    fwd1_hit_rs1 = fwd1_writes & (fwd1_rd_addr == in_rs1_addr);
    fwd1_hit_rs2 = fwd1_writes & (fwd1_rd_addr == in_rs2_addr);
    fwd2_hit_rs1 = fwd2_writes & (fwd2_rd_addr == in_rs1_addr);
    fwd2_hit_rs2 = fwd2_writes & (fwd2_rd_addr == in_rs2_addr);
  end

  always_comb begin
    fwd_a = in_rs1_data;
    if (in_rs1_addr == '0)  fwd_a = '0;
    else if (fwd1_hit_rs1)  fwd_a = fwd1_result;
    else if (fwd2_hit_rs1)  fwd_a = fwd2_result;
  end

  always_comb begin
    fwd_b = in_rs2_data;
    if (in_rs2_addr == '0)  fwd_b = '0;
    else if (fwd1_hit_rs2)  fwd_b = fwd1_result;
    else if (fwd2_hit_rs2)  fwd_b = fwd2_result;
  end

  // rs2 matters for register-register ops and for stores (imm form that
  // neither loads nor writes rd still consumes rs2 as store data).
  always_comb begin
    rs2_used     = ~in_use_imm | (~in_reg_write & ~in_is_load);
    hazard_stall = ~reset & in_valid & fwd1_valid & fwd1_is_load &
                   (fwd1_hit_rs1 | (fwd1_hit_rs2 & rs2_used));
    capture      = ~flush & ~hazard_stall & in_valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid      <= 1'b0;
      alu_control    <= '0;
      source_A       <= '0;
      source_B       <= '0;
      out_store_data <= '0;
      out_rd_addr    <= '0;
      out_reg_write  <= 1'b0;
      out_is_load    <= 1'b0;
    end else if (!stall) begin
      if (capture) begin
        out_valid      <= 1'b1;
        alu_control    <= in_alu_control;
        source_A       <= in_use_pc  ? in_pc  : fwd_a;
        source_B       <= in_use_imm ? in_imm : fwd_b;
        out_store_data <= fwd_b;
        out_rd_addr    <= in_rd_addr;
        out_reg_write  <= in_reg_write;
        out_is_load    <= in_is_load;
      end else begin
        out_valid      <= 1'b0;
        alu_control    <= '0;
        source_A       <= '0;
        source_B       <= '0;
        out_store_data <= '0;
        out_rd_addr    <= '0;
        out_reg_write  <= 1'b0;
        out_is_load    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage with a behavioural reference model
// compared every cycle, plus hand-computed literal expectations.
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, in_valid;
  logic [3:0]  in_alu_control;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm, in_pc;
  logic        in_use_imm, in_use_pc, in_reg_write, in_is_load;
  logic        fwd1_valid, fwd1_reg_write, fwd1_is_load;
  logic [4:0]  fwd1_rd_addr;
  logic [31:0] fwd1_result;
  logic        fwd2_valid, fwd2_reg_write;
  logic [4:0]  fwd2_rd_addr;
  logic [31:0] fwd2_result;
  logic        hazard_stall, out_valid, out_reg_write, out_is_load;
  logic [3:0]  alu_control;
  logic [31:0] source_A, source_B, out_store_data;
  logic [4:0]  out_rd_addr;

  int n_cmp = 0;
  int n_bad = 0;

  ex_operand_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_alu_control(in_alu_control),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_pc(in_pc), .in_use_imm(in_use_imm), .in_use_pc(in_use_pc),
    .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write), .in_is_load(in_is_load),
    .fwd1_valid(fwd1_valid), .fwd1_reg_write(fwd1_reg_write), .fwd1_is_load(fwd1_is_load),
    .fwd1_rd_addr(fwd1_rd_addr), .fwd1_result(fwd1_result),
    .fwd2_valid(fwd2_valid), .fwd2_reg_write(fwd2_reg_write),
    .fwd2_rd_addr(fwd2_rd_addr), .fwd2_result(fwd2_result),
    .hazard_stall(hazard_stall), .out_valid(out_valid), .alu_control(alu_control),
    .source_A(source_A), .source_B(source_B), .out_store_data(out_store_data),
    .out_rd_addr(out_rd_addr), .out_reg_write(out_reg_write), .out_is_load(out_is_load)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] rf);
    if (idx == 0) return 32'h0;
    if (fwd1_valid && fwd1_reg_write && fwd1_rd_addr == idx) return fwd1_result;
    if (fwd2_valid && fwd2_reg_write && fwd2_rd_addr == idx) return fwd2_result;
    return rf;
  endfunction

  function automatic logic model_hazard();
    logic uses_rs2;
    if (reset || !in_valid) return 1'b0;
    if (!(fwd1_valid && fwd1_is_load && fwd1_reg_write) || fwd1_rd_addr == 0) return 1'b0;
    uses_rs2 = !in_use_imm || (!in_reg_write && !in_is_load);
    return (fwd1_rd_addr == in_rs1_addr) || (uses_rs2 && fwd1_rd_addr == in_rs2_addr);
  endfunction

  logic        m_valid, m_rw, m_ld;
  logic [3:0]  m_ctl;
  logic [31:0] m_a, m_b, m_sd;
  logic [4:0]  m_rd;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_valid <= 0; m_ctl <= 0; m_a <= 0; m_b <= 0; m_sd <= 0; m_rd <= 0; m_rw <= 0; m_ld <= 0;
    end else if (stall) begin
      // everything holds
    end else if (flush || model_hazard() || !in_valid) begin
      m_valid <= 0; m_ctl <= 0; m_a <= 0; m_b <= 0; m_sd <= 0; m_rd <= 0; m_rw <= 0; m_ld <= 0;
    end else begin
      m_valid <= 1;
      m_ctl   <= in_alu_control;
      m_a     <= in_use_pc ? in_pc : operand(in_rs1_addr, in_rs1_data);
      m_b     <= in_use_imm ? in_imm : operand(in_rs2_addr, in_rs2_data);
      m_sd    <= operand(in_rs2_addr, in_rs2_data);
      m_rd    <= in_rd_addr;
      m_rw    <= in_reg_write;
      m_ld    <= in_is_load;
    end
  end

  always @(posedge clk) begin
    #2;
    chk("m_out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    chk("m_alu_control", {28'b0, alu_control}, {28'b0, m_ctl});
    chk("m_source_A", source_A, m_a);
    chk("m_source_B", source_B, m_b);
    chk("m_store_data", out_store_data, m_sd);
    chk("m_rd_addr", {27'b0, out_rd_addr}, {27'b0, m_rd});
    chk("m_reg_write", {31'b0, out_reg_write}, {31'b0, m_rw});
    chk("m_is_load", {31'b0, out_is_load}, {31'b0, m_ld});
    chk("m_hazard_stall", {31'b0, hazard_stall}, {31'b0, model_hazard()});
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic clear_inputs();
    stall = 0; flush = 0; in_valid = 0; in_alu_control = 0;
    in_rs1_addr = 0; in_rs2_addr = 0; in_rd_addr = 0;
    in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_pc = 0;
    in_use_imm = 0; in_use_pc = 0; in_reg_write = 0; in_is_load = 0;
    fwd1_valid = 0; fwd1_reg_write = 0; fwd1_is_load = 0; fwd1_rd_addr = 0; fwd1_result = 0;
    fwd2_valid = 0; fwd2_reg_write = 0; fwd2_rd_addr = 0; fwd2_result = 0;
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    tick(); tick();
    chk("reset_valid", {31'b0, out_valid}, 32'h0);
    chk("reset_srcA", source_A, 32'h0);
    chk("reset_hazard", {31'b0, hazard_stall}, 32'h0);
    #2 reset = 0;
    tick();

    // Forward priority on rs1
    in_valid = 1; in_alu_control = 4'h3; in_reg_write = 1; in_rd_addr = 5'd9;
    in_rs1_addr = 5; in_rs1_data = 32'h1111; in_rs2_addr = 6; in_rs2_data = 32'h2222;
    fwd1_valid = 1; fwd1_reg_write = 1; fwd1_rd_addr = 5; fwd1_result = 32'hAAAA0000;
    fwd2_valid = 1; fwd2_reg_write = 1; fwd2_rd_addr = 5; fwd2_result = 32'h5555;
    tick();
    chk("fwd1_wins", source_A, 32'hAAAA0000);
    chk("fwd_valid", {31'b0, out_valid}, 32'h1);
    chk("rf_rs2", source_B, 32'h2222);
    fwd1_reg_write = 0;
    tick();
    chk("fwd2_used", source_A, 32'h5555);
    fwd2_reg_write = 0;
    tick();
    chk("rf_used", source_A, 32'h1111);

    // x0 guard on rs2
    in_rs2_addr = 0; in_rs2_data = 32'h99;
    fwd1_reg_write = 1; fwd1_rd_addr = 0; fwd1_result = 32'hFFFFFFFF;
    tick();
    chk("x0_srcB", source_B, 32'h0);
    chk("x0_store", out_store_data, 32'h0);

    // Load-use bubble, then forward from fwd2
    fwd1_is_load = 1; fwd1_rd_addr = 7; fwd1_result = 32'hDEAD;
    in_rs1_addr = 7; in_rs1_data = 32'h0BAD;
    #1 chk("lu_hazard", {31'b0, hazard_stall}, 32'h1);
    tick();
    chk("lu_bubble", {31'b0, out_valid}, 32'h0);
    fwd1_valid = 0; fwd1_is_load = 0;
    fwd2_valid = 1; fwd2_reg_write = 1; fwd2_rd_addr = 7; fwd2_result = 32'h42;
    #1 chk("lu_clear", {31'b0, hazard_stall}, 32'h0);
    tick();
    chk("lu_fwd", source_A, 32'h42);
    chk("lu_valid", {31'b0, out_valid}, 32'h1);

    // Store rs2 counts as a use; imm ALU op does not
    fwd2_valid = 0;
    fwd1_valid = 1; fwd1_reg_write = 1; fwd1_is_load = 1; fwd1_rd_addr = 4;
    in_rs1_addr = 1; in_rs2_addr = 4; in_use_imm = 1; in_reg_write = 0; in_is_load = 0;
    #1 chk("store_hazard", {31'b0, hazard_stall}, 32'h1);
    in_reg_write = 1;
    #1 chk("imm_no_hazard", {31'b0, hazard_stall}, 32'h0);
    fwd1_is_load = 0;

    // Immediate / PC select with forwarded store data
    in_use_pc = 1; in_pc = 32'h100; in_use_imm = 1; in_imm = 32'hFFFFF800;
    in_rs2_addr = 3; in_rs2_data = 32'h1; fwd1_rd_addr = 3; fwd1_result = 32'h77;
    tick();
    chk("pc_srcA", source_A, 32'h100);
    chk("imm_srcB", source_B, 32'hFFFFF800);
    chk("store_fwd", out_store_data, 32'h77);

    // Stall + flush: stall wins
    in_pc = 32'h200; stall = 1; flush = 1;
    for (int unsigned i = 0; i < 3; i++) tick();
    chk("sf_hold_A", source_A, 32'h100);
    chk("sf_hold_v", {31'b0, out_valid}, 32'h1);
    stall = 0;
    tick();
    chk("flush_bubble", {31'b0, out_valid}, 32'h0);
    chk("flush_zero", source_A, 32'h0);
    flush = 0; in_pc = 32'h1234;
    tick();
    chk("recapture", source_A, 32'h1234);
    stall = 1; in_pc = 32'h5678;
    tick(); tick();
    chk("stall_frozen", source_A, 32'h1234);

    // Asynchronous reset mid-stream
    reset = 1;
    #1;
    chk("areset_valid", {31'b0, out_valid}, 32'h0);
    chk("areset_srcA", source_A, 32'h0);
    chk("areset_hazard", {31'b0, hazard_stall}, 32'h0);
    #2 reset = 0;
    clear_inputs();
    tick();

    // Mixed traffic over a small register window, checked by the model
    for (int unsigned i = 0; i < 40; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_alu_control = 4'($urandom);
      in_rs1_addr = 5'($urandom_range(0, 3)); in_rs2_addr = 5'($urandom_range(0, 3));
      in_rd_addr = 5'($urandom); in_rs1_data = $urandom; in_rs2_data = $urandom;
      in_imm = $urandom; in_pc = $urandom;
      in_use_imm = 1'($urandom); in_use_pc = 1'($urandom);
      in_reg_write = 1'($urandom); in_is_load = 1'($urandom);
      fwd1_valid = 1'($urandom); fwd1_reg_write = 1'($urandom); fwd1_is_load = 1'($urandom);
      fwd1_rd_addr = 5'($urandom_range(0, 3)); fwd1_result = $urandom;
      fwd2_valid = 1'($urandom); fwd2_reg_write = 1'($urandom);
      fwd2_rd_addr = 5'($urandom_range(0, 3)); fwd2_result = $urandom;
      stall = $urandom_range(0, 7) == 0; flush = $urandom_range(0, 7) == 0;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
